// File: rtl/reg_file_mp.sv
// Multi-read-port register file with one masked synchronous write port,
// NUM_RD combinational read ports, optional write-to-read forwarding and a
// sequential bulk-clear engine that walks every entry once.
module reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            w_addr,
    input  logic [DATA_WIDTH-1:0]            w_data,
    input  logic [DATA_WIDTH-1:0]            w_mask,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     r_data,
    input  logic                             clr_req,
    output logic                             clr_busy,
    output logic                             clr_done,
    output logic                             wr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be in 1..4");
    end

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic                    wr_fire;
    logic                    clr_start;
    logic                    clr_last;

    // Read-modify-write value for the addressed entry; shared by the write
    // path and the forwarding path so both see exactly the same merge.
    assign wr_merged = (mem[w_addr] & ~w_mask) | (w_data & w_mask);

    // Busy is taken straight from the state register, so it is glitch-free.
    assign clr_busy = (state == CLEAR);

    // Next-state logic: writes only land in IDLE, a clear runs until the
    // pointer has visited the last entry.
    always_comb begin
        state_next = state;
        wr_fire    = 1'b0;
        clr_start  = 1'b0;
        clr_last   = 1'b0;
        case (state)
            IDLE: begin
                wr_fire = wr_en;
                if (clr_req) begin
                    state_next = CLEAR;
                    clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                clr_last = (ptr == LAST_ADDR);
                if (clr_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear pointer: restarts at entry 0 on every new clear, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr_start) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

    // One-cycle status pulses: clear finished, write dropped during clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            clr_done <= clr_last;
            wr_err   <= (state == CLEAR) && wr_en;
        end
    end

    // Storage: reset always zeroes (independent of CLR_VALUE); the clear
    // engine owns the array while active, otherwise the masked write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= CLR_VALUE;
        end else if (wr_fire) begin
            mem[w_addr] <= wr_merged;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read port k: array lookup, with same-cycle forwarding of an
        // accepted write when enabled (never during a clear).
        always_comb begin
            rd = mem[ra];
            if ((BYPASS != 0) && wr_fire && (ra == w_addr)) begin
                rd = wr_merged;
            end
        end

        assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed stimulus pushes expected
// observations into a queue, a negedge monitor pops and compares them.
module tb_reg_file_mp;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] w_mask;
    logic [3:0] r_addr;
    logic [15:0] r_data;
    logic [15:0] r_data_nb;
    logic       clr_req;
    logic       clr_busy, clr_done, wr_err;
    logic       clr_busy_nb, clr_done_nb, wr_err_nb;

    int checks = 0;
    int failures = 0;

    // sel: 0/1 = forwarding DUT read port, 2 = clr_busy, 3 = clr_done,
    //      4 = wr_err, 5 = non-forwarding DUT port 1
    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_RD(2), .BYPASS(1),
                  .CLR_VALUE(8'h5A)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .w_mask(w_mask), .r_addr(r_addr), .r_data(r_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_err(wr_err)
    );

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_RD(2), .BYPASS(0),
                  .CLR_VALUE(8'h5A)) dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr),
        .w_data(w_data), .w_mask(w_mask), .r_addr(r_addr), .r_data(r_data_nb),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb),
        .wr_err(wr_err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] probe(input int sel);
        case (sel)
            0: return r_data[7:0];
            1: return r_data[15:8];
            2: return {7'd0, clr_busy};
            3: return {7'd0, clr_done};
            4: return {7'd0, wr_err};
            5: return r_data_nb[15:8];
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: compare everything queued for the current cycle mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            logic [7:0] act;
            cur = sb.pop_front();
            act = probe(cur.sel);
            checks++;
            if (act !== cur.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [7:0] v, input string name);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] a0, input logic [1:0] a1);
        r_addr = {a1, a0};
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m);
        wr_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    task automatic status(input logic b, input logic d, input logic e, input string tag);
        expect_val(2, {7'd0, b}, {tag, "_busy"});
        expect_val(3, {7'd0, d}, {tag, "_done"});
        expect_val(4, {7'd0, e}, {tag, "_wr_err"});
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
        r_addr = '0; clr_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Reset state: all entries zero, status idle
        set_rd(2'd0, 2'd1);
        expect_val(0, 8'h00, "rst_a0"); expect_val(1, 8'h00, "rst_a1");
        status(1'b0, 1'b0, 1'b0, "rst");
        step();
        set_rd(2'd2, 2'd3);
        expect_val(0, 8'h00, "rst_a2"); expect_val(1, 8'h00, "rst_a3");
        step();

        // Masked write: A5/FF then 3C/0F -> AC; forwarding during second write
        write(2'd2, 8'hA5, 8'hFF);
        set_rd(2'd2, 2'd2);
        wr_en = 1'b1; w_addr = 2'd2; w_data = 8'h3C; w_mask = 8'h0F;
        expect_val(0, 8'hAC, "mask_bypass_p0");
        expect_val(5, 8'hA5, "mask_nobypass_p1");
        step();
        wr_en = 1'b0;
        expect_val(0, 8'hAC, "mask_p0"); expect_val(1, 8'hAC, "mask_p1");
        expect_val(5, 8'hAC, "mask_nb_p1");
        step();

        // Same-cycle forwarding vs. old contents
        write(2'd1, 8'h11, 8'hFF);
        set_rd(2'd0, 2'd1);
        wr_en = 1'b1; w_addr = 2'd1; w_data = 8'hF0; w_mask = 8'hFF;
        expect_val(1, 8'hF0, "bypass_p1");
        expect_val(5, 8'h11, "nobypass_p1");
        step();
        wr_en = 1'b0;
        expect_val(1, 8'hF0, "after_wr_p1"); expect_val(5, 8'hF0, "after_wr_nb_p1");
        step();

        // Fill remaining entries, then one clear with a dropped write
        write(2'd0, 8'h01, 8'hFF);
        write(2'd3, 8'h33, 8'hFF);
        clr_req = 1'b1;
        status(1'b0, 1'b0, 1'b0, "clr_c0");
        step();
        clr_req = 1'b0;
        set_rd(2'd0, 2'd1);
        expect_val(0, 8'h01, "clr_c1_a0_old"); expect_val(1, 8'hF0, "clr_c1_a1_old");
        status(1'b1, 1'b0, 1'b0, "clr_c1");
        step();
        set_rd(2'd0, 2'd3);
        wr_en = 1'b1; w_addr = 2'd3; w_data = 8'hFF; w_mask = 8'hFF;
        expect_val(0, 8'h5A, "clr_c2_a0_new"); expect_val(1, 8'h33, "clr_c2_a3_nobyp");
        status(1'b1, 1'b0, 1'b0, "clr_c2");
        step();
        wr_en = 1'b0;
        status(1'b1, 1'b0, 1'b1, "clr_c3");
        step();
        status(1'b1, 1'b0, 1'b0, "clr_c4");
        step();
        set_rd(2'd0, 2'd1);
        expect_val(0, 8'h5A, "clr_end_a0"); expect_val(1, 8'h5A, "clr_end_a1");
        status(1'b0, 1'b1, 1'b0, "clr_c5");
        step();
        set_rd(2'd2, 2'd3);
        expect_val(0, 8'h5A, "clr_end_a2"); expect_val(1, 8'h5A, "clr_end_a3");
        status(1'b0, 1'b0, 1'b0, "clr_c6");
        step();

        // clr_req held across the done edge: one IDLE cycle, then restart
        clr_req = 1'b1;
        status(1'b0, 1'b0, 1'b0, "hold_c0");
        step();
        for (int i = 1; i <= 4; i++) begin
            expect_val(2, 8'h01, $sformatf("hold_c%0d_busy", i));
            step();
        end
        status(1'b0, 1'b1, 1'b0, "hold_c5");
        step();
        clr_req = 1'b0;
        expect_val(2, 8'h01, "hold_c6_busy");
        repeat (4) step();
        status(1'b0, 1'b1, 1'b0, "hold_end");
        step();

        // Reset asserted during the 3rd clear cycle
        write(2'd2, 8'h99, 8'hFF);
        write(2'd3, 8'h99, 8'hFF);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        set_rd(2'd2, 2'd3);
        expect_val(0, 8'h00, "rstmid_a2"); expect_val(1, 8'h00, "rstmid_a3");
        status(1'b0, 1'b0, 1'b0, "rstmid");
        step();
        reset = 1'b1;
        set_rd(2'd0, 2'd1);
        expect_val(0, 8'h00, "rstmid_a0"); expect_val(1, 8'h00, "rstmid_a1");
        for (int i = 0; i < 5; i++) begin
            status(1'b0, 1'b0, 1'b0, $sformatf("post_rst%0d", i));
            step();
        end

        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
